scan_chain_sequencer: RTL and testbench

//  Host-side controller for the accumulator microcontroller's scan chain and run control.

---
 rtl/scan_chain_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_scan_chain_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_sequencer.sv
// rtl/scan_chain_sequencer.sv - scan chain load/readback and run-control sequencer
module scan_chain_sequencer #(
    parameter int CHAIN_LEN   = 152,
    parameter int RUN_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd,
    output logic        cmd_ready,
    input  logic        abort,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_ready,
    output logic        scan_enable,
    output logic        scan_in,
    input  logic        scan_out,
    output logic        proc_en,
    input  logic        halt,
    output logic        done,
    output logic        timeout,
    output logic [15:0] run_cycles
);
    localparam int            BW       = $clog2(CHAIN_LEN + 1);
    localparam logic [BW-1:0] BITS_ALL = BW'(CHAIN_LEN);
    localparam logic [BW-1:0] BITS_ONE = BW'(1);
    localparam logic [15:0]   RUN_LAST = 16'(RUN_TIMEOUT - 1);
    localparam logic [1:0]    CMD_LOAD = 2'b00;
    localparam logic [1:0]    CMD_RUN  = 2'b01;
    localparam logic [1:0]    CMD_READ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_WAIT,
        S_LD_SHIFT,
        S_RUN,
        S_RD_SHIFT,
        S_RD_HOLD
    } state_t;

    state_t          state;
    state_t          nxt;
    logic            done_nxt;
    logic [BW-1:0]   bits_left;
    logic [2:0]      bit_idx;
    logic [6:0]      load_sreg;
    logic            load_bit;
    logic            last_bit;
    logic            byte_end;
    logic            run_limit;

    assign last_bit  = (bits_left == BITS_ONE);
    assign byte_end  = (bit_idx == 3'd7) || last_bit;
    assign run_limit = (run_cycles == RUN_LAST);

    // Readback recirculates the chain tail straight back into its head so
    // the chain sees no extra pipeline stage; loading drives a registered bit.
    assign scan_in = (state == S_RD_SHIFT) ? scan_out : load_bit;

    // Next state and completion pulse; abort overrides every transition.
    always_comb begin
        nxt      = state;
        done_nxt = 1'b0;
        if (abort) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd)
                            CMD_LOAD: nxt = S_LD_WAIT;
                            CMD_READ: nxt = S_RD_SHIFT;
                            CMD_RUN: begin
                                if (halt) begin
                                    done_nxt = 1'b1;
                                end else begin
                                    nxt = S_RUN;
                                end
                            end
                            default: done_nxt = 1'b1;
                        endcase
                    end
                end
                S_LD_WAIT: begin
                    if (wr_valid) nxt = S_LD_SHIFT;
                end
                S_LD_SHIFT: begin
                    if (last_bit) begin
                        nxt      = S_IDLE;
                        done_nxt = 1'b1;
                    end else if (bit_idx == 3'd7) begin
                        nxt = S_LD_WAIT;
                    end
                end
                S_RUN: begin
                    if (halt || run_limit) begin
                        nxt      = S_IDLE;
                        done_nxt = 1'b1;
                    end
                end
                S_RD_SHIFT: begin
                    if (byte_end) nxt = S_RD_HOLD;
                end
                S_RD_HOLD: begin
                    if (rd_ready) begin
                        if (bits_left == '0) begin
                            nxt      = S_IDLE;
                            done_nxt = 1'b1;
                        end else begin
                            nxt = S_RD_SHIFT;
                        end
                    end
                end
                default: nxt = S_IDLE;
            endcase
        end
    end

    // State register, registered outputs decoded from the next state, and datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b1;
            wr_ready    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= 8'h00;
            scan_enable <= 1'b0;
            proc_en     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            run_cycles  <= 16'h0000;
            bits_left   <= '0;
            bit_idx     <= 3'd0;
            load_sreg   <= 7'h00;
            load_bit    <= 1'b0;
        end else begin
            state       <= nxt;
            cmd_ready   <= (nxt == S_IDLE);
            wr_ready    <= (nxt == S_LD_WAIT);
            rd_valid    <= (nxt == S_RD_HOLD);
            scan_enable <= (nxt == S_LD_SHIFT) || (nxt == S_RD_SHIFT);
            proc_en     <= (nxt == S_RUN);
            done        <= done_nxt;

            // Every proc_en-high cycle counts, including one cut short by abort.
            if (state == S_RUN && run_cycles != 16'hFFFF) begin
                run_cycles <= run_cycles + 16'd1;
            end

            if (!abort) begin
                case (state)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            bits_left <= BITS_ALL;
                            bit_idx   <= 3'd0;
                            if (cmd == CMD_READ) rd_data <= 8'h00;
                            if (cmd == CMD_RUN) begin
                                run_cycles <= 16'h0000;
                                timeout    <= 1'b0;
                            end
                        end
                    end
                    S_LD_WAIT: begin
                        if (wr_valid) begin
                            load_bit  <= wr_data[0];
                            load_sreg <= wr_data[7:1];
                            bit_idx   <= 3'd0;
                        end
                    end
                    S_LD_SHIFT: begin
                        load_bit  <= load_sreg[0];
                        load_sreg <= {1'b0, load_sreg[6:1]};
                        bits_left <= bits_left - BITS_ONE;
                        bit_idx   <= bit_idx + 3'd1;
                    end
                    S_RUN: begin
                        // A simultaneous halt takes priority over the timeout flag.
                        if (run_limit && !halt) timeout <= 1'b1;
                    end
                    S_RD_SHIFT: begin
                        rd_data[bit_idx] <= scan_out;
                        bits_left        <= bits_left - BITS_ONE;
                        bit_idx          <= bit_idx + 3'd1;
                    end
                    S_RD_HOLD: begin
                        if (rd_ready && bits_left != '0) begin
                            rd_data <= 8'h00;
                            bit_idx <= 3'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// tb/tb_scan_chain_sequencer.sv - directed self-checking bench for scan_chain_sequencer
module tb_scan_chain_sequencer;
    localparam int LEN_A = 152;
    localparam int LEN_B = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] cmd;
    logic       cmd_valid, abort, wr_valid, rd_ready, halt, sel_b;
    logic [7:0] wr_data;

    logic cmd_valid_a, wr_valid_a, cmd_ready_a, wr_ready_a, rd_valid_a;
    logic scan_enable_a, scan_in_a, scan_out_a, proc_en_a, done_a, timeout_a;
    logic [7:0] rd_data_a;
    logic [15:0] run_cycles_a;
    logic cmd_valid_b, wr_valid_b, cmd_ready_b, wr_ready_b, rd_valid_b;
    logic scan_enable_b, scan_in_b, scan_out_b, proc_en_b, done_b, timeout_b;
    logic [7:0] rd_data_b;
    logic [15:0] run_cycles_b;

    logic [LEN_A-1:0] chain_a = '0;
    logic [LEN_B-1:0] chain_b = '0;
    logic [LEN_A-1:0] exp_a;
    logic [7:0] ld_q[$];

    int n_vec = 0;
    int n_bad = 0;

    assign cmd_valid_a = cmd_valid & ~sel_b;
    assign cmd_valid_b = cmd_valid & sel_b;
    assign wr_valid_a  = wr_valid & ~sel_b;
    assign wr_valid_b  = wr_valid & sel_b;

    logic cmd_ready_s, wr_ready_s, rd_valid_s, se_s, pe_s, done_s, timeout_s;
    logic [7:0]  rd_data_s;
    logic [15:0] run_cycles_s;
    assign cmd_ready_s  = sel_b ? cmd_ready_b   : cmd_ready_a;
    assign wr_ready_s   = sel_b ? wr_ready_b    : wr_ready_a;
    assign rd_valid_s   = sel_b ? rd_valid_b    : rd_valid_a;
    assign se_s         = sel_b ? scan_enable_b : scan_enable_a;
    assign pe_s         = sel_b ? proc_en_b     : proc_en_a;
    assign done_s       = sel_b ? done_b        : done_a;
    assign timeout_s    = sel_b ? timeout_b     : timeout_a;
    assign rd_data_s    = sel_b ? rd_data_b     : rd_data_a;
    assign run_cycles_s = sel_b ? run_cycles_b  : run_cycles_a;

    // Behavioural chains: head at MSB, tail at bit 0.
    assign scan_out_a = chain_a[0];
    assign scan_out_b = chain_b[0];
    always @(posedge clk) if (scan_enable_a) chain_a <= {scan_in_a, chain_a[LEN_A-1:1]};
    always @(posedge clk) if (scan_enable_b) chain_b <= {scan_in_b, chain_b[LEN_B-1:1]};

    scan_chain_sequencer #(.CHAIN_LEN(LEN_A), .RUN_TIMEOUT(1024)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd(cmd), .cmd_ready(cmd_ready_a),
        .abort(abort), .wr_valid(wr_valid_a), .wr_data(wr_data), .wr_ready(wr_ready_a),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_ready(rd_ready),
        .scan_enable(scan_enable_a), .scan_in(scan_in_a), .scan_out(scan_out_a),
        .proc_en(proc_en_a), .halt(halt), .done(done_a), .timeout(timeout_a),
        .run_cycles(run_cycles_a)
    );

    scan_chain_sequencer #(.CHAIN_LEN(LEN_B), .RUN_TIMEOUT(64)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd(cmd), .cmd_ready(cmd_ready_b),
        .abort(abort), .wr_valid(wr_valid_b), .wr_data(wr_data), .wr_ready(wr_ready_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_ready(rd_ready),
        .scan_enable(scan_enable_b), .scan_in(scan_in_b), .scan_out(scan_out_b),
        .proc_en(proc_en_b), .halt(halt), .done(done_b), .timeout(timeout_b),
        .run_cycles(run_cycles_b)
    );

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scan_enable and proc_en must never be high together.
    always @(negedge clk) begin
        if (rst) begin
            check("excl_a", {159'd0, scan_enable_a & proc_en_a}, 160'd0);
            check("excl_b", {159'd0, scan_enable_b & proc_en_b}, 160'd0);
        end
    end

    task automatic load_bytes(input int exp_done, input int exp_se, input string tag);
        int idx = 0;
        int se = 0;
        int done_at = -1;
        int nb = ld_q.size();
        logic prev;
        @(negedge clk); cmd = 2'b00; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = ld_q[0];
        prev = wr_ready_s;
        for (int n = 1; n < 400 && done_at < 0; n++) begin
            @(negedge clk);
            if (prev) idx++;
            wr_data = (idx < nb) ? ld_q[idx] : 8'h00;
            prev = wr_ready_s;
            if (se_s) se++;
            if (done_s) done_at = n;
        end
        wr_valid = 1'b0;
        check({tag, "_bytes"}, idx, nb);
        check({tag, "_se_cycles"}, se, exp_se);
        check({tag, "_done_cycle"}, done_at, exp_done);
        @(negedge clk);
        check({tag, "_done_pulse"}, done_s, 0);
        check({tag, "_cmd_ready"}, cmd_ready_s, 1);
    endtask

    task automatic run_cmd(input int halt_at, input int window, input int exp_pe,
                           input logic exp_to, input string tag);
        int pe = 0;
        int dn = 0;
        int nlow = -1;
        @(negedge clk); cmd = 2'b01; cmd_valid = 1'b1; halt = (halt_at == 0);
        @(negedge clk); cmd_valid = 1'b0;
        for (int n = 0; n < window; n++) begin
            if (n > 0) @(negedge clk);
            if (pe_s) pe++;
            if (done_s) dn++;
            if (!pe_s && nlow < 0) nlow = n;
            if (halt_at > 0 && pe == halt_at && pe_s) halt = 1'b1;
        end
        halt = 1'b0;
        check({tag, "_pe_cycles"}, pe, exp_pe);
        check({tag, "_pe_drop"}, nlow, exp_pe);
        check({tag, "_run_cycles"}, run_cycles_s, exp_pe);
        check({tag, "_timeout"}, timeout_s, exp_to);
        check({tag, "_done_count"}, dn, 1);
    endtask

    task automatic read_b(input int hold, input logic [7:0] e0, input logic [7:0] e1,
                          input string tag);
        logic [7:0] got0 = 8'h00;
        logic [7:0] got1 = 8'h00;
        logic [7:0] cap = 8'h00;
        int k = 0;
        int held = 0;
        int dn = 0;
        int se = 0;
        int unstable = 0;
        @(negedge clk); cmd = 2'b10; cmd_valid = 1'b1; rd_ready = 1'b0;
        @(negedge clk); cmd_valid = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (n > 0) @(negedge clk);
            if (done_s) dn++;
            if (se_s) se++;
            rd_ready = 1'b0;
            if (rd_valid_s) begin
                if (held == 0) cap = rd_data_s;
                else if (rd_data_s !== cap || se_s) unstable++;
                if (held >= hold) begin
                    rd_ready = 1'b1;
                    if (k == 0) got0 = rd_data_s;
                    if (k == 1) got1 = rd_data_s;
                    k++;
                    held = 0;
                end else begin
                    held++;
                end
            end
        end
        rd_ready = 1'b0;
        check({tag, "_byte0"}, got0, e0);
        check({tag, "_byte1"}, got1, e1);
        check({tag, "_nbytes"}, k, 2);
        check({tag, "_shifts"}, se, LEN_B);
        check({tag, "_done_count"}, dn, 1);
        check({tag, "_hold_stable"}, unstable, 0);
        check({tag, "_chain"}, chain_b, 13'h1FA5);
    endtask

    initial begin
        rst = 1'b0; cmd = 2'b00; cmd_valid = 1'b0; abort = 1'b0; wr_valid = 1'b0;
        wr_data = 8'h00; rd_ready = 1'b0; halt = 1'b0; sel_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready_a, 1);
        check("rst_wr_ready", wr_ready_a, 0);
        check("rst_rd_valid", rd_valid_a, 0);
        check("rst_rd_data", rd_data_a, 0);
        check("rst_scan_enable", scan_enable_a, 0);
        check("rst_proc_en", proc_en_a, 0);
        check("rst_done", done_a, 0);
        check("rst_timeout", timeout_a, 0);
        check("rst_run_cycles", run_cycles_a, 0);
        rst = 1'b1;

        // 152-bit LOAD of bytes 0x00..0x12, wr_valid held high
        ld_q.delete();
        for (int k = 0; k < 19; k++) ld_q.push_back(8'(k));
        load_bytes(171, LEN_A, "ld152");
        for (int k = 0; k < 19; k++) exp_a[8*k +: 8] = ld_q[k];
        check("ld152_image", chain_a, exp_a);

        // RUN halted after 37 cycles, then RUN with halt already high
        run_cmd(37, 60, 37, 1'b0, "run_halt37");
        run_cmd(0, 5, 0, 1'b0, "run_halt_acc");

        // 13-bit chain: load, two plain reads, one slow-host read
        sel_b = 1'b1;
        ld_q.delete();
        ld_q.push_back(8'hA5);
        ld_q.push_back(8'hFF);
        load_bytes(15, LEN_B, "ld13");
        check("ld13_image", chain_b, 13'h1FA5);
        read_b(0, 8'hA5, 8'h1F, "rd1");
        read_b(0, 8'hA5, 8'h1F, "rd2");
        read_b(10, 8'hA5, 8'h1F, "rd_slow");

        // Timeout, sticky clear on next RUN, halt coinciding with timeout
        run_cmd(-1, 100, 64, 1'b1, "run_to");
        run_cmd(0, 5, 0, 1'b0, "run_to_clr");
        run_cmd(64, 100, 64, 1'b0, "run_halt_to");

        // abort with cmd_valid in IDLE is not accepted
        @(negedge clk); cmd = 2'b00; cmd_valid = 1'b1; abort = 1'b1;
        @(negedge clk); cmd_valid = 1'b0; abort = 1'b0;
        check("abort_cmd_wr_ready", wr_ready_s, 0);
        check("abort_cmd_cmd_ready", cmd_ready_s, 1);

        // Reserved command
        @(negedge clk); cmd = 2'b11; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        check("rsv_done", done_s, 1);
        check("rsv_cmd_ready", cmd_ready_s, 1);
        @(negedge clk);
        check("rsv_done_pulse", done_s, 0);

        // abort while holding a readback byte
        @(negedge clk); cmd = 2'b10; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        for (int n = 0; n < 20 && !rd_valid_s; n++) @(negedge clk);
        check("ab_hold_reached", rd_valid_s, 1);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("ab_rd_valid", rd_valid_s, 0);
        check("ab_scan_enable", se_s, 0);
        check("ab_cmd_ready", cmd_ready_s, 1);
        check("ab_done", done_s, 0);
        repeat (3) @(negedge clk);
        check("ab_done_late", done_s, 0);

        // Asynchronous reset mid-LD_SHIFT and mid-RUN, then a clean reload
        sel_b = 1'b0;
        @(negedge clk); cmd = 2'b00; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'hC3;
        repeat (4) @(negedge clk);
        check("rstld_se_before", se_s, 1);
        #2 rst = 1'b0;
        #1;
        check("rstld_se_async", se_s, 0);
        wr_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("rstld_cmd_ready", cmd_ready_s, 1);

        @(negedge clk); cmd = 2'b01; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("rstrun_pe_before", pe_s, 1);
        #2 rst = 1'b0;
        #1;
        check("rstrun_pe_async", pe_s, 0);
        check("rstrun_run_cycles", run_cycles_s, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("rstrun_cmd_ready", cmd_ready_s, 1);

        ld_q.delete();
        for (int k = 0; k < 19; k++) ld_q.push_back(8'(k) ^ 8'h5A);
        load_bytes(171, LEN_A, "reload");
        for (int k = 0; k < 19; k++) exp_a[8*k +: 8] = ld_q[k];
        check("reload_image", chain_a, exp_a);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
